// File: rtl/fifo8x9_ctrl.sv
// Push/pop sequencer for the 8x9 FIFO storage block: drives its pointer strobes and shadows pointers/count.
// Optional sticky overflow/underflow flags are built when FIFO8X9_CTRL_ERR_EN is defined.
module fifo8x9_ctrl #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic              flush,
    output logic              push_ack,
    output logic              pop_ack,
    output logic              wren,
    output logic              WrInc,
    output logic              rden,
    output logic              RdInc,
    output logic              WrPtrClr,
    output logic              RdPtrClr,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              err_ovf,
    output logic              err_udf,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        CLR  = 2'd3
    } state_t;

    state_t state;
    logic   last_op_wr;
    logic   can_push;
    logic   can_pop;

    // Handshake: push_req/pop_req are levels held by the requester until the
    // matching ack; each ack is a one-cycle pulse in the WR/RD cycle and the
    // transfer happens on the edge that closes that cycle.  A request dropped
    // before its ack is not served.
    assign can_push = push_req && !full;
    assign can_pop  = pop_req && !empty;

    assign full  = (count == (ADDR_W+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_op_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush)
                        state <= CLR;
                    else if (can_push && can_pop)
                        state <= last_op_wr ? RD : WR;
                    else if (can_push)
                        state <= WR;
                    else if (can_pop)
                        state <= RD;
                end
                WR: begin
                    wr_ptr     <= wr_ptr + ADDR_W'(1);
                    count      <= count + (ADDR_W+1)'(1);
                    last_op_wr <= 1'b1;
                    state      <= IDLE;
                end
                RD: begin
                    rd_ptr     <= rd_ptr + ADDR_W'(1);
                    count      <= count - (ADDR_W+1)'(1);
                    last_op_wr <= 1'b0;
                    state      <= IDLE;
                end
                CLR: begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode: strobes depend on the state register alone.
    assign wren      = (state == WR);
    assign WrInc     = (state == WR);
    assign push_ack  = (state == WR);
    assign rden      = (state == RD);
    assign RdInc     = (state == RD);
    assign pop_ack   = (state == RD);
    assign WrPtrClr  = (state == CLR);
    assign RdPtrClr  = (state == CLR);
    assign state_dbg = state;

`ifdef FIFO8X9_CTRL_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else if (state == IDLE) begin
            if (flush) begin
                err_ovf <= 1'b0;
                err_udf <= 1'b0;
            end else begin
                if (push_req && full)
                    err_ovf <= 1'b1;
                if (pop_req && empty)
                    err_udf <= 1'b1;
            end
        end
    end
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Directed bench for fifo8x9_ctrl with a behavioural model of the 8x9 storage block.
// Build with FIFO8X9_CTRL_ERR_EN defined to expect the sticky error flags.
module tb_fifo8x9_ctrl;

`ifdef FIFO8X9_CTRL_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_req = 1'b0;
    logic       pop_req = 1'b0;
    logic       flush = 1'b0;
    logic       push_ack, pop_ack, wren, WrInc, rden, RdInc, WrPtrClr, RdPtrClr;
    logic [2:0] wr_ptr, rd_ptr;
    logic [3:0] count;
    logic       full, empty, err_ovf, err_udf;
    logic [1:0] state_dbg;

    logic [8:0] din = 9'h000;
    logic [8:0] dout;
    logic [8:0] mem [8];
    logic [2:0] m_wp, m_rp;

    int n_cmp  = 0;
    int n_fail = 0;

    fifo8x9_ctrl #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .push_req(push_req), .pop_req(pop_req), .flush(flush),
        .push_ack(push_ack), .pop_ack(pop_ack), .wren(wren), .WrInc(WrInc),
        .rden(rden), .RdInc(RdInc), .WrPtrClr(WrPtrClr), .RdPtrClr(RdPtrClr),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count), .full(full), .empty(empty),
        .err_ovf(err_ovf), .err_udf(err_udf), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Storage block: pointers are moved only by the controller's strobes.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wp <= 3'd0;
            m_rp <= 3'd0;
        end else begin
            if (wren) mem[m_wp] <= din;
            if (WrPtrClr) m_wp <= 3'd0;
            else if (WrInc) m_wp <= m_wp + 3'd1;
            if (RdPtrClr) m_rp <= 3'd0;
            else if (RdInc) m_rp <= m_rp + 3'd1;
        end
    end
    assign dout = rden ? mem[m_rp] : 9'h000;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks start and end at posedge+1 with the FSM in IDLE.
    task automatic push_n(input int n, input logic [8:0] base);
        int t;
        push_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            din = base + 9'(i);
            t = 0;
            do begin @(negedge clk); t++; end while (push_ack !== 1'b1 && t < 6);
            n_cmp++;
            if (push_ack !== 1'b1 || t != 2) begin
                n_fail++;
                $display("FAIL push_ack_timing: got ack=%b after %0d cycles, required 1 after 2", push_ack, t);
            end
            n_cmp++;
            if ({wren, WrInc, pop_ack, rden} !== 4'b1100) begin
                n_fail++;
                $display("FAIL push_strobes: got %b, required 1100", {wren, WrInc, pop_ack, rden});
            end
            @(posedge clk); #1;
        end
        push_req = 1'b0;
    endtask

    task automatic pop_n(input int n, input logic [8:0] base);
        int t;
        pop_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (pop_ack !== 1'b1 && t < 6);
            n_cmp++;
            if (pop_ack !== 1'b1 || t != 2) begin
                n_fail++;
                $display("FAIL pop_ack_timing: got ack=%b after %0d cycles, required 1 after 2", pop_ack, t);
            end
            n_cmp++;
            if ({rden, RdInc, push_ack, wren} !== 4'b1100 || dout !== base + 9'(i)) begin
                n_fail++;
                $display("FAIL pop_data: got strobes %b data %h, required 1100 data %h",
                         {rden, RdInc, push_ack, wren}, dout, base + 9'(i));
            end
            @(posedge clk); #1;
        end
        pop_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({state_dbg, count, empty, full, push_ack, pop_ack, wren, rden, WrPtrClr, err_ovf, err_udf} !== 15'b00_0000_10_0000000) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d cnt=%0d e=%b f=%b", state_dbg, count, empty, full);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push_n(1, 9'h055);
        n_cmp++;
        if (count !== 4'd1 || wr_ptr !== 3'd1) begin
            n_fail++;
            $display("FAIL pre_async_count: got cnt=%0d wp=%0d, required 1/1", count, wr_ptr);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({count, wr_ptr, empty, full, wren, WrInc, rden, RdInc} !== 13'b0000_000_10_0000) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d wp=%0d e=%b f=%b", count, wr_ptr, empty, full);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        push_n(8, 9'h101);
        n_cmp++;
        if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0 || wr_ptr !== 3'd0) begin
            n_fail++;
            $display("FAIL fill_final: got cnt=%0d f=%b e=%b wp=%0d, required 8 1 0 0", count, full, empty, wr_ptr);
        end
        push_req = 1'b1;
        din = 9'h1FF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (push_ack !== 1'b0 || wren !== 1'b0) begin
                n_fail++;
                $display("FAIL push_when_full: got ack=%b wren=%b, required 0 0", push_ack, wren);
            end
        end
        @(posedge clk); #1;
        push_req = 1'b0;
        n_cmp++;
        if (err_ovf !== ERR_EN || count !== 4'd8) begin
            n_fail++;
            $display("FAIL err_ovf: got %b cnt=%0d, required %b 8", err_ovf, count, ERR_EN);
        end
    endtask

    task automatic test_drain();
        pop_n(8, 9'h101);
        n_cmp++;
        if (empty !== 1'b1 || full !== 1'b0 || rd_ptr !== 3'd0 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL drain_final: got e=%b f=%b rp=%0d cnt=%0d, required 1 0 0 0", empty, full, rd_ptr, count);
        end
        pop_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (pop_ack !== 1'b0 || rden !== 1'b0) begin
                n_fail++;
                $display("FAIL pop_when_empty: got ack=%b rden=%b, required 0 0", pop_ack, rden);
            end
        end
        @(posedge clk); #1;
        pop_req = 1'b0;
        n_cmp++;
        if (err_udf !== ERR_EN || err_ovf !== ERR_EN) begin
            n_fail++;
            $display("FAIL err_udf: got udf=%b ovf=%b, required %b %b", err_udf, err_ovf, ERR_EN, ERR_EN);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_cnt [4];
        logic [2:0] exp_wp  [4];
        logic [2:0] exp_rp  [4];
        int t;
        exp_cnt = '{4'd4, 4'd3, 4'd4, 4'd3};
        exp_wp  = '{3'd5, 3'd5, 3'd6, 3'd6};
        exp_rp  = '{3'd1, 3'd2, 3'd2, 3'd3};
        push_n(4, 9'h1A0);
        pop_n(1, 9'h1A0);
        din = 9'h1C0;
        push_req = 1'b1;
        pop_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (push_ack !== 1'b1 && pop_ack !== 1'b1 && t < 6);
            n_cmp++;
            if (push_ack !== (i % 2 == 0) || pop_ack !== (i % 2 == 1) || t != 2) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got push=%b pop=%b after %0d, required push=%b after 2",
                         i, push_ack, pop_ack, t, (i % 2 == 0));
            end
            if (i == 1 || i == 3) begin
                n_cmp++;
                if (dout !== 9'h1A0 + 9'((i + 1) / 2)) begin
                    n_fail++;
                    $display("FAIL rr_data[%0d]: got %h, required %h", i, dout, 9'h1A0 + 9'((i + 1) / 2));
                end
            end
            @(posedge clk); #1;
            n_cmp++;
            if (count !== exp_cnt[i] || wr_ptr !== exp_wp[i] || rd_ptr !== exp_rp[i]) begin
                n_fail++;
                $display("FAIL rr_ptrs[%0d]: got cnt=%0d wp=%0d rp=%0d, required %0d %0d %0d",
                         i, count, wr_ptr, rd_ptr, exp_cnt[i], exp_wp[i], exp_rp[i]);
            end
        end
        push_req = 1'b0;
        pop_req  = 1'b0;
    endtask

    task automatic test_flush();
        push_n(2, 9'h1B0);
        n_cmp++;
        if (count !== 4'd5 || wr_ptr !== 3'd0 || err_ovf !== ERR_EN) begin
            n_fail++;
            $display("FAIL flush_pre: got cnt=%0d wp=%0d ovf=%b, required 5 0 %b", count, wr_ptr, err_ovf, ERR_EN);
        end
        din = 9'h1D0;
        flush = 1'b1;
        push_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({WrPtrClr, RdPtrClr, push_ack, wren, err_ovf, err_udf} !== 6'b110000) begin
            n_fail++;
            $display("FAIL flush_clr: got %b, required 110000", {WrPtrClr, RdPtrClr, push_ack, wren, err_ovf, err_udf});
        end
        flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== 4'd0 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0 || empty !== 1'b1 || WrPtrClr !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: got cnt=%0d wp=%0d rp=%0d e=%b clr=%b, required 0 0 0 1 0",
                     count, wr_ptr, rd_ptr, empty, WrPtrClr);
        end
        @(negedge clk);
        n_cmp++;
        if (push_ack !== 1'b1 || wren !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_push_served: got ack=%b wren=%b, required 1 1", push_ack, wren);
        end
        @(posedge clk); #1;
        push_req = 1'b0;
        n_cmp++;
        if (count !== 4'd1 || wr_ptr !== 3'd1) begin
            n_fail++;
            $display("FAIL flush_push_count: got cnt=%0d wp=%0d, required 1 1", count, wr_ptr);
        end
    endtask

    task automatic test_reset_mid_wr();
        din = 9'h1E0;
        push_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (state_dbg !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_wr_state: got %0d, required 1", state_dbg);
        end
        rst = 1'b1;
        push_req = 1'b0;
        #1;
        n_cmp++;
        if (push_ack !== 1'b0 || wren !== 1'b0 || state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_wr_reset: got ack=%b wren=%b st=%0d, required 0 0 0", push_ack, wren, state_dbg);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (push_ack !== 1'b0 || count !== 4'd0 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin
                n_fail++;
                $display("FAIL after_reset: got ack=%b cnt=%0d wp=%0d rp=%0d, required 0 0 0 0",
                         push_ack, count, wr_ptr, rd_ptr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_round_robin();
        test_flush();
        test_reset_mid_wr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
